// File: rtl/rb_access_sequencer_if.sv
// Handshake and bank/memory signal bundle for the register-bank access sequencer.
// The master side issues microinstructions and answers memory requests; the slave side is the sequencer.
interface rb_access_sequencer_if;
  logic       ui_valid;
  logic       ui_ready;
  logic [4:0] ui_busA;
  logic [5:0] ui_busB;
  logic [5:0] ui_busC;
  logic [1:0] ui_MC;
  logic [4:0] busA;
  logic [5:0] busB;
  logic [5:0] busC;
  logic       regRead;
  logic       workRegRead;
  logic       regWrite;
  logic       workRegWrite;
  logic       dataC_sel;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;
  logic       done;
  logic       err;

  modport master (
    output ui_valid, ui_busA, ui_busB, ui_busC, ui_MC, mem_ack,
    input  ui_ready, busA, busB, busC, regRead, workRegRead, regWrite, workRegWrite,
           dataC_sel, mem_req, mem_we, done, err
  );

  modport slave (
    input  ui_valid, ui_busA, ui_busB, ui_busC, ui_MC, mem_ack,
    output ui_ready, busA, busB, busC, regRead, workRegRead, regWrite, workRegWrite,
           dataC_sel, mem_req, mem_we, done, err
  );
endinterface

// File: rtl/rb_access_sequencer.sv
// Microinstruction sequencer for the 36-entry register bank: READ -> EXEC -> (MEM) -> WRITE -> DONE,
// with all bank, memory and handshake outputs registered.
module rb_access_sequencer #(
  parameter logic [5:0]  WR_IDX   = 6'd34,
  parameter logic [5:0]  NOP_IDX  = 6'd35,
  parameter int unsigned EXEC_CYC = 2,
  parameter int unsigned MEM_TMO  = 15
) (
  input logic                  clk,
  input logic                  rst,
  rb_access_sequencer_if.slave seq
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_MEM_WR, S_MEM_RD, S_WRITE, S_DONE
  } state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYC - 1);
  localparam logic [7:0] TMO_LAST  = 8'(MEM_TMO - 1);

  state_t     state;
  logic [1:0] mc;
  logic [3:0] exec_cnt;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      mc                <= '0;
      exec_cnt          <= '0;
      wait_cnt          <= '0;
      seq.ui_ready      <= 1'b1;
      seq.busA          <= '0;
      seq.busB          <= '0;
      seq.busC          <= '0;
      seq.regRead       <= 1'b0;
      seq.workRegRead   <= 1'b0;
      seq.regWrite      <= 1'b0;
      seq.workRegWrite  <= 1'b0;
      seq.dataC_sel     <= 1'b0;
      seq.mem_req       <= 1'b0;
      seq.mem_we        <= 1'b0;
      seq.done          <= 1'b0;
      seq.err           <= 1'b0;
    end else begin
      // NOTE: single-cycle pulses default low here; a later non-blocking assignment in the case below wins.
      seq.regRead      <= 1'b0;
      seq.workRegRead  <= 1'b0;
      seq.regWrite     <= 1'b0;
      seq.workRegWrite <= 1'b0;
      seq.done         <= 1'b0;
      seq.err          <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (seq.ui_valid) begin
            seq.ui_ready <= 1'b0;
            // An illegal MC retires immediately with err and leaves the bank buses untouched.
            if (seq.ui_MC == 2'b11) begin
              seq.err  <= 1'b1;
              seq.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              seq.busA        <= seq.ui_busA;
              seq.busB        <= seq.ui_busB;
              seq.busC        <= seq.ui_busC;
              mc              <= seq.ui_MC;
              seq.regRead     <= 1'b1;
              seq.workRegRead <= (seq.ui_busB == WR_IDX);
              state           <= S_READ;
            end
          end
        end

        S_READ: begin
          exec_cnt <= EXEC_LOAD;
          state    <= S_EXEC;
        end

        S_EXEC: begin
          if (exec_cnt != '0) begin
            exec_cnt <= exec_cnt - 4'd1;
          end else if (mc[0]) begin
            seq.mem_req <= 1'b1;
            seq.mem_we  <= 1'b1;
            wait_cnt    <= '0;
            state       <= S_MEM_WR;
          end else if (mc[1]) begin
            seq.mem_req <= 1'b1;
            seq.mem_we  <= 1'b0;
            wait_cnt    <= '0;
            state       <= S_MEM_RD;
          end else if (seq.busC == NOP_IDX) begin
            seq.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            seq.regWrite     <= (seq.busC != WR_IDX);
            seq.workRegWrite <= (seq.busC == WR_IDX);
            state            <= S_WRITE;
          end
        end

        S_MEM_WR, S_MEM_RD: begin
          if (seq.mem_ack) begin
            seq.mem_req <= 1'b0;
            seq.mem_we  <= 1'b0;
            // Read data lands in the working register regardless of the requested destination.
            if (state == S_MEM_RD) begin
              seq.busC         <= WR_IDX;
              seq.dataC_sel    <= 1'b1;
              seq.workRegWrite <= 1'b1;
              state            <= S_WRITE;
            end else if (seq.busC == NOP_IDX) begin
              seq.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              seq.regWrite     <= (seq.busC != WR_IDX);
              seq.workRegWrite <= (seq.busC == WR_IDX);
              state            <= S_WRITE;
            end
          end else if (wait_cnt == TMO_LAST) begin
            seq.mem_req <= 1'b0;
            seq.mem_we  <= 1'b0;
            seq.err     <= 1'b1;
            seq.done    <= 1'b1;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_WRITE: begin
          seq.dataC_sel <= 1'b0;
          seq.done      <= 1'b1;
          state         <= S_DONE;
        end

        S_DONE: begin
          seq.ui_ready <= 1'b1;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rb_access_sequencer.sv
// Scoreboard bench for rb_access_sequencer: stimulus queues the outcome predicted from the operation rules,
// a negedge monitor collects what the bank/memory pins did per microinstruction and compares on done.
module tb_rb_access_sequencer;

  localparam logic [5:0] WR_IDX   = 6'd34;
  localparam logic [5:0] NOP_IDX  = 6'd35;
  localparam int         EXEC_CYC = 2;
  localparam int         MEM_TMO  = 15;

  typedef struct {
    int         lat;
    int         memcyc;
    bit         rr, wrr, rw, wrw, dsel, memwe, err;
    logic [4:0] a;
    logic [5:0] b, busc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rb_access_sequencer_if ifc ();

  rb_access_sequencer #(
    .WR_IDX(WR_IDX), .NOP_IDX(NOP_IDX), .EXEC_CYC(EXEC_CYC), .MEM_TMO(MEM_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seq(ifc.slave)
  );

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   ack_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Outcome of one microinstruction derived from the operation rules; ackd = cycle of mem_ack, 0 = never.
  function automatic exp_t model(input logic [4:0] a, input logic [5:0] b, input logic [5:0] c,
                                 input logic [1:0] mc, input int ackd);
    exp_t       e;
    int         wb;
    logic [5:0] tgt;
    e = '{lat: 0, memcyc: 0, rr: 0, wrr: 0, rw: 0, wrw: 0, dsel: 0, memwe: 0, err: 0,
          a: a, b: b, busc: '0};
    if (mc == 2'b11) begin
      e.err = 1;
      e.lat = 1;
      return e;
    end
    e.rr  = 1;
    e.wrr = (b == WR_IDX);
    tgt   = c;
    wb    = (c != NOP_IDX) ? 1 : 0;
    if (mc != 2'b00) begin
      e.memwe = (mc == 2'b01);
      if (ackd == 0) begin
        e.memcyc = MEM_TMO;
        e.err    = 1;
        wb       = 0;
      end else begin
        e.memcyc = ackd;
        if (mc == 2'b10) begin
          tgt    = WR_IDX;
          e.dsel = 1;
          wb     = 1;
        end
      end
    end
    if (wb != 0) begin
      e.busc = tgt;
      if (tgt == WR_IDX) e.wrw = 1;
      else               e.rw  = 1;
    end
    e.lat = 2 + EXEC_CYC + e.memcyc + wb;
    return e;
  endfunction

  // Memory responder: acks on the ack_delay-th request cycle, random noise on mem_ack otherwise.
  initial begin
    int req_cnt = 0;
    ifc.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.mem_req) begin
        req_cnt++;
        ifc.mem_ack = (ack_delay != 0 && req_cnt == ack_delay);
      end else begin
        req_cnt     = 0;
        ifc.mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: accumulate pin activity per accepted microinstruction, compare against the scoreboard on done.
  initial begin
    int   cyc = 0, acc_cyc = 0;
    bit   in_op = 0, done_prev = 0;
    int   rr_n, wrr_n, rw_n, wrw_n, mem_n, we_n, err_n;
    logic [4:0] a_seen;
    logic [5:0] b_seen, c_seen;
    logic       dsel_seen;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_op     = 0;
        done_prev = 0;
      end else begin
        if (done_prev) begin
          check("ui_ready_after_done", ifc.ui_ready, 1);
          done_prev = 0;
        end
        if (in_op) begin
          if (ifc.regRead) begin rr_n++; a_seen = ifc.busA; b_seen = ifc.busB; end
          if (ifc.workRegRead) wrr_n++;
          if (ifc.regWrite || ifc.workRegWrite) begin c_seen = ifc.busC; dsel_seen = ifc.dataC_sel; end
          if (ifc.regWrite) rw_n++;
          if (ifc.workRegWrite) wrw_n++;
          if (ifc.mem_req) mem_n++;
          if (ifc.mem_we) we_n++;
          if (ifc.err) err_n++;
          if (ifc.done) begin
            check("scoreboard_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("done_latency", cyc - acc_cyc, e.lat);
              check("regRead_pulses", rr_n, e.rr);
              check("workRegRead_pulses", wrr_n, e.wrr);
              if (e.rr) begin
                check("busA_at_read", a_seen, e.a);
                check("busB_at_read", b_seen, e.b);
              end
              check("regWrite_pulses", rw_n, e.rw);
              check("workRegWrite_pulses", wrw_n, e.wrw);
              if (e.rw || e.wrw) begin
                check("busC_at_write", c_seen, e.busc);
                check("dataC_sel_at_write", dsel_seen, e.dsel);
              end
              check("mem_req_cycles", mem_n, e.memcyc);
              check("mem_we_cycles", we_n, e.memwe ? e.memcyc : 0);
              check("err_pulses", err_n, e.err);
              check("dataC_sel_at_done", ifc.dataC_sel, 0);
            end
            in_op     = 0;
            done_prev = 1;
          end
        end else begin
          check("idle_quiet", {ifc.regRead, ifc.workRegRead, ifc.regWrite, ifc.workRegWrite,
                               ifc.mem_req, ifc.mem_we, ifc.done, ifc.err}, 0);
          if (ifc.ui_valid && ifc.ui_ready) begin
            in_op   = 1;
            acc_cyc = cyc;
            rr_n = 0; wrr_n = 0; rw_n = 0; wrw_n = 0; mem_n = 0; we_n = 0; err_n = 0;
            a_seen = 'x; b_seen = 'x; c_seen = 'x; dsel_seen = 1'bx;
          end
        end
      end
    end
  end

  task automatic drive_ui(input logic [4:0] a, input logic [5:0] b, input logic [5:0] c,
                          input logic [1:0] mc);
    int n = 0;
    ifc.ui_valid = 1'b1;
    ifc.ui_busA  = a;
    ifc.ui_busB  = b;
    ifc.ui_busC  = c;
    ifc.ui_MC    = mc;
    while (!ifc.ui_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("ui_ready_wait", ifc.ui_ready, 1);
    @(posedge clk); #1;
    ifc.ui_valid = 1'b0;
    ifc.ui_busA  = 5'($urandom);
    ifc.ui_busB  = 6'($urandom);
    ifc.ui_busC  = 6'($urandom);
    ifc.ui_MC    = 2'($urandom);
  endtask

  task automatic issue(input logic [4:0] a, input logic [5:0] b, input logic [5:0] c,
                       input logic [1:0] mc, input int ackd);
    int n = 0;
    sb.push_back(model(a, b, c, mc, ackd));
    ack_delay = ackd;
    drive_ui(a, b, c, mc);
    while (!ifc.done && n < 100) begin @(posedge clk); #1; n++; end
    check("done_wait", ifc.done, 1);
  endtask

  initial begin
    logic [5:0] b, c;
    logic [1:0] mc;
    int         r, ackd, n;
    ifc.ui_valid = 1'b0;
    ifc.ui_busA  = '0;
    ifc.ui_busB  = '0;
    ifc.ui_busC  = '0;
    ifc.ui_MC    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ui_ready", ifc.ui_ready, 1);
    check("rst_outputs_zero", {ifc.busA, ifc.busB, ifc.busC, ifc.regRead, ifc.workRegRead,
                               ifc.regWrite, ifc.workRegWrite, ifc.dataC_sel, ifc.mem_req,
                               ifc.mem_we, ifc.done, ifc.err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(5'd1, 6'd2,  6'd3,  2'b00, 0);
    issue(5'd0, 6'd34, 6'd34, 2'b00, 0);
    issue(5'd7, 6'd9,  6'd5,  2'b10, 3);
    issue(5'd3, 6'd4,  6'd35, 2'b01, 1);
    issue(5'd2, 6'd6,  6'd7,  2'b10, 0);
    issue(5'd5, 6'd1,  6'd12, 2'b01, MEM_TMO);
    issue(5'd4, 6'd34, 6'd35, 2'b00, 0);
    issue(5'd8, 6'd0,  6'd34, 2'b01, 2);
    issue(5'd6, 6'd3,  6'd35, 2'b10, 1);
    issue(5'd9, 6'd9,  6'd9,  2'b11, 0);

    for (int i = 0; i < 40; i++) begin
      r    = $urandom_range(0, 9);
      mc   = (r < 4 || r == 9) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      b    = ($urandom_range(0, 3) == 0) ? WR_IDX : 6'($urandom_range(0, 63));
      r    = $urandom_range(0, 3);
      c    = (r == 0) ? WR_IDX : (r == 1) ? NOP_IDX : 6'($urandom_range(0, 33));
      ackd = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, MEM_TMO);
      issue(5'($urandom), b, c, mc, ackd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset while a memory read is outstanding.
    ack_delay = 0;
    drive_ui(5'd1, 6'd1, 6'd2, 2'b10);
    n = 0;
    while (!ifc.mem_req && n < 20) begin @(posedge clk); #1; n++; end
    check("mem_req_before_reset", ifc.mem_req, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midop_rst_ui_ready", ifc.ui_ready, 1);
    check("midop_rst_quiet", {ifc.regRead, ifc.workRegRead, ifc.regWrite, ifc.workRegWrite,
                              ifc.dataC_sel, ifc.mem_req, ifc.mem_we, ifc.done, ifc.err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(5'd11, 6'd12, 6'd13, 2'b00, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
